// File: rtl/t_cnt_pkg.sv
// t_cnt_pkg: shared constants and next-state helpers for t_cell_counter.
// Optional feature macro: T_CNT_DIR_EN (bidirectional counting).
package t_cnt_pkg;

    // Widest counter the helpers support; callers extend/truncate to WIDTH.
    localparam int unsigned CNT_MAX_W = 16;

    // Direction encodings for the up/down select.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Next count value for an enabled cycle. Out-of-range states recover
    // to 0 when counting up and to modulus-1 when counting down.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] q,
        input logic                 up,
        input int unsigned          modulus
    );
        int unsigned qv;
        int unsigned nv;
        qv = 32'(q);
        nv = 0;
        if (up == DIR_UP) begin
            if (qv >= modulus - 1) begin
                nv = 0;
            end else begin
                nv = qv + 1;
            end
        end else begin
            if ((qv == 0) || (qv >= modulus)) begin
                nv = modulus - 1;
            end else begin
                nv = qv - 1;
            end
        end
        return CNT_MAX_W'(nv);
    endfunction

    // Parallel-load value clamped into the legal count range.
    function automatic logic [CNT_MAX_W-1:0] clamp_load(
        input logic [CNT_MAX_W-1:0] val,
        input int unsigned          modulus
    );
        int unsigned vv;
        vv = 32'(val);
        if (vv >= modulus) begin
            vv = modulus - 1;
        end
        return CNT_MAX_W'(vv);
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: single T-type storage cell with asynchronous active-high reset.
module t_ff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;
    logic q_d;

    // Toggle the stored bit whenever t is asserted.
    always_comb begin
        q_d = q_q ^ t;
    end

    // State register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/t_cell_counter.sv
// t_cell_counter: modulo-MODULUS counter built from WIDTH T cells.
// The top computes the next count, derives the per-bit toggle vector
// t_vec = q ^ next, and flags the wrapping cycle on tc.
// Optional feature macro: T_CNT_DIR_EN adds the up port and down counting.
module t_cell_counter
    import t_cnt_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef T_CNT_DIR_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t_vec,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             dir;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] wrap_val;

    // Direction select; fixed to up when bidirectional support is absent.
`ifdef T_CNT_DIR_EN
    always_comb begin
        dir = up;
    end
`else
    always_comb begin
        dir = DIR_UP;
    end
`endif

    // Next count with priority load > en > hold.
    always_comb begin
        next_val = q;
        if (load) begin
            next_val = WIDTH'(clamp_load(CNT_MAX_W'(load_val), MODULUS));
        end else if (en) begin
            next_val = WIDTH'(next_count(CNT_MAX_W'(q), dir, MODULUS));
        end
    end

    // Toggle vector and terminal count; both forced low while reset is held.
    always_comb begin
        wrap_val = (dir == DIR_UP) ? MAX_VAL : '0;
        if (reset) begin
            t_vec = '0;
            tc    = 1'b0;
        end else begin
            t_vec = q ^ next_val;
            tc    = en & ~load & (q == wrap_val);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t_vec[i]),
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_t_cell_counter.sv
// Directed bench for t_cell_counter: one modulo-16 and one modulo-10 instance.
module tb_t_cell_counter;

    logic       clk;
    logic       reset;

    logic       en_a, load_a;
    logic [3:0] lv_a, q_a, t_a;
    logic       tc_a;

    logic       en_b, load_b;
    logic [3:0] lv_b, q_b, t_b;
    logic       tc_b;

`ifdef T_CNT_DIR_EN
    logic       up_a, up_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_t;
    int         v;

    t_cell_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .en       (en_a),
        .load     (load_a),
        .load_val (lv_a),
`ifdef T_CNT_DIR_EN
        .up       (up_a),
`endif
        .q        (q_a),
        .t_vec    (t_a),
        .tc       (tc_a)
    );

    t_cell_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .en       (en_b),
        .load     (load_b),
        .load_val (lv_b),
`ifdef T_CNT_DIR_EN
        .up       (up_b),
`endif
        .q        (q_b),
        .t_vec    (t_b),
        .tc       (tc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        en_a = 1'b1; load_a = 1'b0; lv_a = '0;
        en_b = 1'b0; load_b = 1'b0; lv_b = '0;
`ifdef T_CNT_DIR_EN
        up_a = 1'b1; up_b = 1'b1;
`endif
        // Reset held for two cycles with en=1
        step();
        step();
        check("rst_q_a",  32'(q_a),  32'd0);
        check("rst_t_a",  32'(t_a),  32'd0);
        check("rst_tc_a", 32'(tc_a), 32'd0);
        check("rst_q_b",  32'(q_b),  32'd0);
        reset = 1'b0;
        #1;

        // Full modulo-16 sequence
        for (int i = 0; i < 16; i++) begin
            exp_t = 4'(i) ^ 4'((i + 1) % 16);
            check("m16_q",  32'(q_a),  32'(i));
            check("m16_tc", 32'(tc_a), 32'(i == 15));
            check("m16_t",  32'(t_a),  32'(exp_t));
            if (i == 7) check("m16_t_at7", 32'(t_a), 32'hF);
            step();
        end
        check("m16_wrap_q", 32'(q_a), 32'd0);
        en_a = 1'b0;

        // Modulo-10 wrap
        en_b = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            v = i % 10;
            check("m10_q",   32'(q_b),  32'(v));
            check("m10_tc",  32'(tc_b), 32'(v == 9));
            check("m10_rng", 32'(q_b <= 4'd9), 32'd1);
            step();
        end

        // Loads on the modulo-10 counter (q is 2 here)
        load_b = 1'b1; lv_b = 4'd5; en_b = 1'b1;
        #1;
        check("ld5_t",  32'(t_b),  32'd7);
        check("ld5_tc", 32'(tc_b), 32'd0);
        step();
        check("ld5_q",  32'(q_b),  32'd5);
        lv_b = 4'd12; en_b = 1'b0;
        #1;
        check("ld12_t", 32'(t_b), 32'd12);
        step();
        check("ld12_q", 32'(q_b), 32'd9);
        lv_b = 4'd3; en_b = 1'b1;
        #1;
        check("ld_at9_tc", 32'(tc_b), 32'd0);
        check("ld_at9_t",  32'(t_b),  32'd10);
        step();
        check("ld3_q", 32'(q_b), 32'd3);
        lv_b = 4'd10;
        step();
        check("ld10_q", 32'(q_b), 32'd9);
        load_b = 1'b0; en_b = 1'b0;

        // In-range load at the top of the modulo-16 range
        load_a = 1'b1; lv_a = 4'd15;
        step();
        check("ld15_q", 32'(q_a), 32'd15);

        // Hold at 6 for three cycles
        lv_a = 4'd6;
        step();
        load_a = 1'b0; en_a = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("hold_q",  32'(q_a),  32'd6);
            check("hold_t",  32'(t_a),  32'd0);
            check("hold_tc", 32'(tc_a), 32'd0);
            step();
        end

        // Asynchronous reset between edges at q=11
        load_a = 1'b1; lv_a = 4'd11; en_a = 1'b1;
        step();
        load_a = 1'b0;
        #1;
        check("pre_rst_q", 32'(q_a), 32'd11);
        check("pre_rst_t", 32'(t_a), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check("arst_q_a",  32'(q_a),  32'd0);
        check("arst_t_a",  32'(t_a),  32'd0);
        check("arst_tc_a", 32'(tc_a), 32'd0);
        check("arst_q_b",  32'(q_b),  32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rel_q", 32'(q_a), 32'd0);
        check("rel_t", 32'(t_a), 32'd1);
        step();
        check("rel_cnt_q", 32'(q_a), 32'd1);
        en_a = 1'b0;

`ifdef T_CNT_DIR_EN
        // Down counting on the modulo-10 counter, then a direction flip
        up_b = 1'b0; load_b = 1'b1; lv_b = 4'd1;
        step();
        load_b = 1'b0; en_b = 1'b1;
        #1;
        check("dn_q1",  32'(q_b),  32'd1);
        check("dn_tc1", 32'(tc_b), 32'd0);
        step();
        check("dn_q0",  32'(q_b),  32'd0);
        check("dn_tc0", 32'(tc_b), 32'd1);
        check("dn_t0",  32'(t_b),  32'd9);
        step();
        check("dn_q9",  32'(q_b),  32'd9);
        check("dn_tc9", 32'(tc_b), 32'd0);
        step();
        check("dn_q8",  32'(q_b),  32'd8);
        up_b = 1'b1;
        #1;
        check("flip_q8", 32'(q_b),  32'd8);
        check("flip_t",  32'(t_b),  32'd1);
        check("flip_tc", 32'(tc_b), 32'd0);
        step();
        check("up_q9",  32'(q_b),  32'd9);
        check("up_tc9", 32'(tc_b), 32'd1);
        step();
        check("up_q0", 32'(q_b), 32'd0);
        en_b = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
